// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register slave.
package apb_slave_pkg;

    // Bus transfer state: waiting for a setup phase, or inside the access phase.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Fixed contents of register 0 (read-only identification word).
    localparam logic [DATA_W-1:0] ID_VALUE = 32'hA5B0_0001;

    // Merge new write data into an old word, one byte lane per strobe bit.
    function automatic logic [DATA_W-1:0] apply_strobe(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array: register 0 is a constant ID word, registers 1..NUM_REGS-1
// are read/write with byte-lane strobes. The read port is a combinational mux
// so data is available in the same cycle the bus completes the transfer.
module apb_reg_bank
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              we_i,
    input  logic [5:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [5:0]        raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : gen_reg
            localparam logic [5:0] REG_IDX = 6'(gi);

            // One storage word: cleared by reset, byte-merged on a matching write.
            always_ff @(posedge clk_i) begin
                if (srst_i) begin
                    regs_q[gi] <= '0;
                end else if (we_i && (waddr_i == REG_IDX)) begin
                    regs_q[gi] <= apply_strobe(regs_q[gi], wdata_i, wstrb_i);
                end
            end
        end
    endgenerate

    // Read mux: index 0 returns the ID constant, indices past the array return 0.
    always_comb begin
        rdata_o = '0;
        if (raddr_i == 6'd0) begin
            rdata_o = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr_i == 6'(i)) begin
                rdata_o = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/apb_slave.sv
// APB slave with a programmable number of wait states in front of a
// byte-strobed register bank. The top keeps the transfer FSM, the wait
// counter and the error decode; response outputs are decoded from the
// registered state and the live bus signals.
module apb_slave
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [STRB_W-1:0] PSTRB,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam logic [2:0]      WAIT_LOAD  = 3'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * NUM_REGS);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              ready;
    logic              addr_err;
    logic              wr_en;
    logic [DATA_W-1:0] bank_rdata;

    // Error decode: misaligned, past the last register, or a write to the ID word.
    always_comb begin
        addr_err = (PADDR[1:0] != 2'b00)
                || ({1'b0, PADDR} >= ADDR_LIMIT)
                || (PWRITE && (PADDR[ADDR_W-1:2] == '0));
    end

    // Completion is decoded live; reset masks it so an aborted access never responds.
    always_comb begin
        ready   = !PRESET && (state_q == ACCESS) && (cnt_q == 3'd0) && PSEL && PENABLE;
        wr_en   = ready && PWRITE && !addr_err;
        PREADY  = ready;
        PSLVERR = ready && addr_err;
        PRDATA  = (ready && !PWRITE && !addr_err) ? bank_rdata : '0;
    end

    // Transfer FSM and wait counter: load on setup, count down, leave on
    // completion or when the master deselects the slave mid-access.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ACCESS;
                        cnt_q   <= WAIT_LOAD;
                    end
                end
                ACCESS: begin
                    if (!PSEL || ready) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_bank (
        .clk_i   (PCLK),
        .srst_i  (PRESET),
        .we_i    (wr_en),
        .waddr_i (PADDR[ADDR_W-1:2]),
        .wdata_i (PWDATA),
        .wstrb_i (PSTRB),
        .raddr_i (PADDR[ADDR_W-1:2]),
        .rdata_o (bank_rdata)
    );

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: two instances (0 and 1 wait states) share the bus
// except for PSEL. A driver pushes expected responses into a queue; a
// monitor pops and compares whenever an instance raises PREADY.
module tb_apb_slave;
    import apb_slave_pkg::*;

    localparam int NREGS = 32;
    localparam int WAITS [2] = '{0, 1};

    logic        PCLK = 1'b0;
    logic        preset;
    logic        psel [2];
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready_w  [2];
    logic [31:0] prdata_w  [2];
    logic        pslverr_w [2];

    always #5 PCLK = ~PCLK;

    apb_slave #(.NUM_REGS(NREGS), .WAIT_CYCLES(0)) u_dut_w0 (
        .PCLK(PCLK), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready_w[0]), .PRDATA(prdata_w[0]), .PSLVERR(pslverr_w[0])
    );

    apb_slave #(.NUM_REGS(NREGS), .WAIT_CYCLES(1)) u_dut_w1 (
        .PCLK(PCLK), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready_w[1]), .PRDATA(prdata_w[1]), .PSLVERR(pslverr_w[1])
    );

    typedef struct {
        int          d;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [2][64];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: an access errors if unaligned, beyond the register file, or writes the ID word.
    function automatic bit addr_err(input bit wr, input logic [7:0] a);
        return (a % 4 != 0) || (int'(a) >= 4 * NREGS) || (wr && (a / 4 == 0));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            model[d][0] = 32'hA5B0_0001;
            for (int i = 1; i < 64; i++) model[d][i] = 32'h0;
        end
    endtask

    // One complete transfer; called at posedge+1 and returns at posedge+1.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
        exp_t e;
        int   cycles;
        bit   got;
        int   idx;
        idx     = int'(a) / 4;
        e.d     = d;
        e.wr    = wr;
        e.addr  = a;
        e.err   = addr_err(wr, a);
        e.rdata = (wr || e.err) ? 32'h0 : model[d][idx];
        exp_q.push_back(e);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = wd; pstrb = st;
        @(posedge PCLK); #1;
        penable = 1'b1;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 16) begin
            @(negedge PCLK);
            cycles++;
            if (pready_w[d] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check("ready_timeout", 32'(cycles), 32'(WAITS[d] + 1));
            void'(exp_q.pop_back());
        end else begin
            check("latency", 32'(cycles), 32'(WAITS[d] + 1));
        end
        @(posedge PCLK); #1;
        if (got && wr && !e.err) begin
            for (int i = 0; i < 4; i++)
                if (st[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    // Monitor: every PREADY pulse must match the oldest expected response;
    // outside PREADY the response outputs must stay at zero.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge PCLK);
            for (int d = 0; d < 2; d++) begin
                if (pready_w[d] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pready: dut%0d got PREADY=1, expected 0 (t=%0t)", d, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("dut_id", 32'(d), 32'(e.d));
                        check("prdata", prdata_w[d], e.rdata);
                        check("pslverr", 32'(pslverr_w[d]), 32'(e.err));
                        $display("[TB] dut%0d %s addr=%h prdata=%h pslverr=%0d",
                                 d, e.wr ? "WR" : "RD", e.addr, prdata_w[d], pslverr_w[d]);
                    end
                end else begin
                    check("idle_prdata", prdata_w[d], 32'h0);
                    check("idle_pslverr", 32'(pslverr_w[d]), 32'h0);
                end
            end
        end
    end

    initial begin : driver
        int          d;
        bit          wr;
        logic [7:0]  a;
        logic [3:0]  st;
        int          gap;

        preset = 1'b1; psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_pready_w1", 32'(pready_w[1]), 32'h0);
        check("reset_pready_w0", 32'(pready_w[0]), 32'h0);
        preset = 1'b0;

        // ID read, strobed write merge, error responses
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0);
        xfer(1, 1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF);
        xfer(1, 1'b1, 8'h08, 32'h1122_3344, 4'b0101);
        xfer(1, 1'b0, 8'h08, 32'h0, 4'h0);
        check("strobe_merge_model", model[1][2], 32'hFF22_FF44);
        xfer(1, 1'b1, 8'h00, 32'h1234_5678, 4'hF);
        xfer(1, 1'b0, 8'h03, 32'h0, 4'h0);
        xfer(1, 1'b0, 8'h80, 32'h0, 4'h0);
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0);

        // PENABLE without a setup phase must be ignored
        psel[1] = 1'b1; penable = 1'b1; paddr = 8'h04; pwrite = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        psel[1] = 1'b0; penable = 1'b0;

        // Master drops PSEL after one wait cycle of a write to 0x14
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h14; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        check("drop_wait_pready", 32'(pready_w[1]), 32'h0);
        @(posedge PCLK); #1;
        psel[1] = 1'b0; penable = 1'b0;
        @(negedge PCLK);
        check("drop_pready", 32'(pready_w[1]), 32'h0);
        @(posedge PCLK); #1;
        xfer(1, 1'b0, 8'h14, 32'h0, 4'h0);

        // Reset during the ready cycle of a write to 0x0C aborts it
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h0C; pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        preset = 1'b1;
        @(negedge PCLK);
        check("abort_pready", 32'(pready_w[1]), 32'h0);
        @(posedge PCLK); #1;
        preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        model_reset();
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0);

        // Zero-wait instance: back-to-back write then read
        xfer(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
        xfer(0, 1'b0, 8'h10, 32'h0, 4'h0);
        check("b2b_model", model[0][4], 32'hDEAD_BEEF);

        // Randomised traffic on both instances
        for (int n = 0; n < 300; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) a = 8'($urandom_range(0, NREGS - 1) * 4);
            else                          a = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            xfer(d, wr, a, $urandom, st);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(posedge PCLK);
                #1;
            end
        end

        repeat (3) @(posedge PCLK);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter NUM_REGS, default 32: number of 32-bit registers, word-addressed from 0x00 to 4*NUM_REGS-4; legal range is 2..64.
REQ-002 Parameter WAIT_CYCLES, default 1: number of access-phase cycles with PREADY low before PREADY rises; legal range is 0..7.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 PCLK  input  1  sole clock, rising edge.
REQ-005 PRESET  input  1  synchronous reset, active-high.
REQ-006 PSEL  input  1  slave select from the master.
REQ-007 PENABLE  input  1  access-phase indicator.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PADDR  input  8  byte address.
REQ-010 PWDATA  input  32  write data.
REQ-011 PSTRB  input  4  byte write strobes; PSTRB[i] enables PWDATA[8i+7:8i].
REQ-012 PREADY  output  1  transfer-complete indicator.
REQ-013 PRDATA  output  32  read data.
REQ-014 PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-015 The FSM SHALL have two states, IDLE and ACCESS.
REQ-016 IDLE -> ACCESS SHALL occur on the edge where PSEL=1 and PENABLE=0 (setup phase); on that edge the wait counter SHALL load WAIT_CYCLES.
REQ-017 In ACCESS, a nonzero wait counter SHALL decrement once per cycle.
REQ-018 PREADY SHALL equal (state==ACCESS && counter==0 && PSEL && PENABLE), decoded from registered state; with WAIT_CYCLES=0 it is therefore high in the first access cycle.
REQ-019 ACCESS -> IDLE SHALL occur on the edge where PSEL, PENABLE and PREADY are all 1 (completion edge).
REQ-020 Back-to-back transfers SHALL be accepted: a setup phase in the cycle after completion is recognised from IDLE with no dead cycle.
REQ-021 If PSEL falls while in ACCESS, the FSM SHALL return to IDLE with no register update and no response.
REQ-022 PENABLE=1 seen in IDLE without a prior setup phase SHALL be ignored.
REQ-023 An address is an error if PADDR[1:0]!=0, or PADDR>=4*NUM_REGS, or the transfer is a write to register 0.
REQ-024 PSLVERR SHALL equal PREADY && error, and SHALL be 0 at all other times.
REQ-025 Register 0 SHALL be a read-only ID register returning 32'hA5B0_0001.
REQ-026 A non-error write SHALL update register[PADDR[7:2]] on the completion edge, byte lanes gated by PSTRB; PSTRB=0 SHALL leave the register unchanged but still complete the transfer without error.
REQ-027 An error write SHALL modify no register.
REQ-028 PRDATA SHALL equal register[PADDR[7:2]] while PREADY=1, PWRITE=0 and the address is not an error; otherwise PRDATA SHALL be 0.
REQ-029 A read SHALL return the value written by the immediately preceding completed write to the same address.
REQ-030 PWDATA, PADDR, PWRITE and PSTRB SHALL be sampled live, not latched; master stability is a bus-protocol obligation.

Reset
REQ-031 While PRESET=1 on a PCLK edge, the FSM SHALL enter IDLE and the wait counter SHALL clear to 0.
REQ-032 During and after reset, PREADY, PSLVERR and PRDATA SHALL all be 0.
REQ-033 Reset SHALL clear registers 1..NUM_REGS-1 to 0.
REQ-034 Reset asserted mid-ACCESS SHALL abort the transfer: no register write, and no PREADY pulse in the reset cycle.

Structure
REQ-035 Package apb_slave_pkg SHALL hold the state enum (IDLE, ACCESS), ADDR_W=8, DATA_W=32, STRB_W=4, and the ID constant 32'hA5B0_0001.
REQ-036 The register array with byte-strobed write port and read mux SHALL be a sub-module apb_reg_bank; apb_slave keeps the FSM, wait counter and error decode.
REQ-037 RTL target is 120-400 lines in total.

Verification
REQ-038 Reset, then read 0x00 with WAIT_CYCLES=1 -> PREADY high in the second access cycle, PRDATA=32'hA5B0_0001, PSLVERR=0.
REQ-039 Write 0x08 with PWDATA=32'h1122_3344 and PSTRB=4'b0101, having first written 32'hFFFF_FFFF there, then read 0x08 -> PRDATA=32'hFF22_FF44.
REQ-040 Write 0x00, then read 0x03, then read 0x80 (NUM_REGS=32) -> each completes with PSLVERR=1, PRDATA=0, and the ID is unchanged.
REQ-041 With WAIT_CYCLES=0, run back-to-back write 0x10=32'hDEAD_BEEF then read 0x10 -> PREADY high in each first access cycle, read returns 32'hDEAD_BEEF.
REQ-042 Assert PRESET during the access phase of a write to 0x0C=32'h5A5A_5A5A, then read 0x0C -> PRDATA=0 and no PREADY in the reset cycle.
REQ-043 Drop PSEL after one wait cycle of a write to 0x14, then read 0x14 -> PRDATA=0 and no PSLVERR seen.
